// File: rtl/alu_nibble_sequencer.sv
// alu_nibble_sequencer
// Drives a 4-bit combinational ALU one nibble at a time (LS nibble first) to
// run a single operation on 4*NIBBLES-bit operands. The ALU carry-out is chained
// into the next nibble's carry-in. Each f[3:0] is collected into the result
// word, and whole-word flags (carry, unsigned a>b, zero) are built along the way.
//
// Result handshake (valid/ready): result_valid rises when the last nibble has
// been captured and stays high, with result and flags frozen, until a cycle in
// which result_ready is also high. That cycle is the transfer. result_valid and
// busy drop on the following cycle. Once result_valid is high it never drops
// without a transfer, except on reset. result and flags stay readable while
// idle until the next start is accepted.
module alu_nibble_sequencer #(
    parameter int NIBBLES = 4,
    parameter int SETTLE  = 1
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   start,
    input  logic [4*NIBBLES-1:0]   op_a,
    input  logic [4*NIBBLES-1:0]   op_b,
    input  logic                   op_cin,
    input  logic [3:0]             op_code,
    output logic                   busy,
    output logic [3:0]             alu_a,
    output logic [3:0]             alu_b,
    output logic                   alu_cin,
    output logic [3:0]             alu_opcode,
    input  logic [7:0]             alu_f,
    input  logic                   alu_cout,
    input  logic                   alu_agtb,
    output logic [4*NIBBLES-1:0]   result,
    output logic                   result_cout,
    output logic                   result_gt,
    output logic                   result_zero,
    output logic                   result_valid,
    input  logic                   result_ready,
    output logic [1:0]             dbg_state
);

    localparam int W     = 4 * NIBBLES;
    localparam int IDX_W = $clog2(NIBBLES);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_DRIVE   = 2'd1;
    localparam logic [1:0] S_CAPTURE = 2'd2;
    localparam logic [1:0] S_DONE    = 2'd3;

    localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(NIBBLES - 1);
    localparam logic [IDX_W-1:0] IDX_ONE     = IDX_W'(1);
    localparam logic [3:0]       SETTLE_LAST = (SETTLE > 0) ? 4'(SETTLE - 1) : 4'd0;
    // Where a nibble goes after start or after a non-final capture.
    localparam logic [1:0]       S_AFTER_STEP = (SETTLE == 0) ? S_CAPTURE : S_DRIVE;

    logic [1:0]       state_q,   state_d;
    logic [IDX_W-1:0] idx_q,     idx_d;
    logic [3:0]       settle_q,  settle_d;
    logic [W-1:0]     a_q,       a_d;
    logic [W-1:0]     b_q,       b_d;
    logic [3:0]       opcode_q,  opcode_d;
    logic             carry_q,   carry_d;
    logic             gt_acc_q,  gt_acc_d;
    logic [W-1:0]     result_q,  result_d;
    logic             cout_q,    cout_d;
    logic             gt_q,      gt_d;
    logic             zero_q,    zero_d;

    // The upper half of the ALU result has no meaning for this sequencer.
    logic unused_alu_f_hi;
    assign unused_alu_f_hi = ^alu_f[7:4];

    // Next-state and datapath update for the nibble sequencing FSM.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        settle_d = settle_q;
        a_d      = a_q;
        b_d      = b_q;
        opcode_d = opcode_q;
        carry_d  = carry_q;
        gt_acc_d = gt_acc_q;
        result_d = result_q;
        cout_d   = cout_q;
        gt_d     = gt_q;
        zero_d   = zero_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_d      = op_a;
                    b_d      = op_b;
                    carry_d  = op_cin;
                    opcode_d = op_code;
                    idx_d    = '0;
                    settle_d = '0;
                    gt_acc_d = 1'b0;
                    result_d = '0;
                    cout_d   = 1'b0;
                    gt_d     = 1'b0;
                    zero_d   = 1'b0;
                    state_d  = S_AFTER_STEP;
                end
            end
            S_DRIVE: begin
                if (settle_q == SETTLE_LAST) begin
                    settle_d = '0;
                    state_d  = S_CAPTURE;
                end else begin
                    settle_d = settle_q + 4'd1;
                end
            end
            S_CAPTURE: begin
                result_d[{idx_q, 2'b00} +: 4] = alu_f[3:0];
                carry_d = alu_cout;
                // A higher nibble decides the comparison; equal nibbles defer
                // to the verdict from the less significant nibbles.
                if (alu_agtb) begin
                    gt_acc_d = 1'b1;
                end else if (alu_a != alu_b) begin
                    gt_acc_d = 1'b0;
                end
                if (idx_q == LAST_IDX) begin
                    cout_d  = alu_cout;
                    gt_d    = gt_acc_d;
                    zero_d  = (result_d == '0);
                    state_d = S_DONE;
                end else begin
                    idx_d   = idx_q + IDX_ONE;
                    state_d = S_AFTER_STEP;
                end
            end
            S_DONE: begin
                if (result_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State registers; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            idx_q    <= '0;
            settle_q <= '0;
            a_q      <= '0;
            b_q      <= '0;
            opcode_q <= '0;
            carry_q  <= 1'b0;
            gt_acc_q <= 1'b0;
            result_q <= '0;
            cout_q   <= 1'b0;
            gt_q     <= 1'b0;
            zero_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            settle_q <= settle_d;
            a_q      <= a_d;
            b_q      <= b_d;
            opcode_q <= opcode_d;
            carry_q  <= carry_d;
            gt_acc_q <= gt_acc_d;
            result_q <= result_d;
            cout_q   <= cout_d;
            gt_q     <= gt_d;
            zero_q   <= zero_d;
        end
    end

    // ALU drive comes straight from registers, so it holds through DRIVE and CAPTURE.
    assign alu_a      = a_q[{idx_q, 2'b00} +: 4];
    assign alu_b      = b_q[{idx_q, 2'b00} +: 4];
    assign alu_cin    = carry_q;
    assign alu_opcode = opcode_q;

    assign busy         = (state_q != S_IDLE);
    assign result_valid = (state_q == S_DONE);
    assign result       = result_q;
    assign result_cout  = cout_q;
    assign result_gt    = gt_q;
    assign result_zero  = zero_q;
    assign dbg_state    = state_q;

endmodule

// File: tb/tb_alu_nibble_sequencer.sv
// Bench for alu_nibble_sequencer: two instances (SETTLE=1 and SETTLE=0), each
// attached to a behavioural 4-bit ALU. Whole-word expectations come from plain
// 16-bit arithmetic.
module tb_alu_nibble_sequencer;

    localparam int W   = 16;
    localparam int EW  = W + 3;
    localparam int LAT = 8;
    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0110;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   cyc = 0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- DUT 0 (defaults) ----------------
    logic         start0 = 0, cin0 = 0, ready0 = 1;
    logic [W-1:0] a0 = 0, b0 = 0;
    logic [3:0]   op0 = 0;
    logic         busy0, alu_cin0, aco0, agtb0, rcout0, rgt0, rzero0, valid0;
    logic [3:0]   alu_a0, alu_b0, alu_op0;
    logic [7:0]   f0;
    logic [W-1:0] res0;
    logic [1:0]   dbg0;

    alu_nibble_sequencer #(.NIBBLES(4), .SETTLE(1)) dut0 (
        .clk(clk), .reset_n(reset_n), .start(start0), .op_a(a0), .op_b(b0),
        .op_cin(cin0), .op_code(op0), .busy(busy0), .alu_a(alu_a0), .alu_b(alu_b0),
        .alu_cin(alu_cin0), .alu_opcode(alu_op0), .alu_f(f0), .alu_cout(aco0),
        .alu_agtb(agtb0), .result(res0), .result_cout(rcout0), .result_gt(rgt0),
        .result_zero(rzero0), .result_valid(valid0), .result_ready(ready0),
        .dbg_state(dbg0)
    );

    // ---------------- DUT 1 (SETTLE=0) ----------------
    logic         start1 = 0, cin1 = 0, ready1 = 1;
    logic [W-1:0] a1 = 0, b1 = 0;
    logic [3:0]   op1 = 0;
    logic         busy1, alu_cin1, aco1, agtb1, rcout1, rgt1, rzero1, valid1;
    logic [3:0]   alu_a1, alu_b1, alu_op1;
    logic [7:0]   f1;
    logic [W-1:0] res1;
    logic [1:0]   dbg1;

    alu_nibble_sequencer #(.NIBBLES(4), .SETTLE(0)) dut1 (
        .clk(clk), .reset_n(reset_n), .start(start1), .op_a(a1), .op_b(b1),
        .op_cin(cin1), .op_code(op1), .busy(busy1), .alu_a(alu_a1), .alu_b(alu_b1),
        .alu_cin(alu_cin1), .alu_opcode(alu_op1), .alu_f(f1), .alu_cout(aco1),
        .alu_agtb(agtb1), .result(res1), .result_cout(rcout1), .result_gt(rgt1),
        .result_zero(rzero1), .result_valid(valid1), .result_ready(ready1),
        .dbg_state(dbg1)
    );

    // ---------------- behavioural 4-bit ALU ----------------
    // Returns {agtb, cout, f[7:0]}; f[7:4] carries junk the sequencer must ignore.
    function automatic logic [9:0] alu_model(input logic [3:0] a, input logic [3:0] b,
                                             input logic cin, input logic [3:0] op);
        logic [4:0] s;
        logic [7:0] f;
        logic       co;
        s  = 5'(a) + 5'(b) + 5'(cin);
        f  = 8'h00;
        co = 1'b0;
        case (op)
            OP_ADD:  begin f = {4'h5, s[3:0]}; co = s[4]; end
            OP_OR:   begin f = {4'hC, a | b}; co = 1'b0; end
            default: begin f = 8'h00; co = 1'b0; end
        endcase
        return {(a > b), co, f};
    endfunction

    always_comb {agtb0, aco0, f0} = alu_model(alu_a0, alu_b0, alu_cin0, alu_op0);
    always_comb {agtb1, aco1, f1} = alu_model(alu_a1, alu_b1, alu_cin1, alu_op1);

    // ---------------- word-level expectation ----------------
    // Packed as {zero, gt, cout, result}.
    function automatic logic [EW-1:0] word_model(input logic [W-1:0] a, input logic [W-1:0] b,
                                                 input logic cin, input logic [3:0] op);
        logic [W:0]   s;
        logic [W-1:0] r;
        logic         co;
        if (op == OP_ADD) begin
            s  = {1'b0, a} + {1'b0, b} + (W+1)'(cin);
            r  = s[W-1:0];
            co = s[W];
        end else begin
            r  = a | b;
            co = 1'b0;
        end
        return {(r == '0), (a > b), co, r};
    endfunction

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_fail   = 0;
    logic [EW-1:0] exp_q[$];
    int   start_cyc = 0;
    logic seen_valid = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Compare process for dut0: every cycle, busy/valid/result against the model.
    always @(negedge clk) begin
        if (!reset_n) begin
            check("rst_busy", 64'(busy0), 64'd0);
            check("rst_valid", 64'(valid0), 64'd0);
            seen_valid = 1'b0;
        end else if (exp_q.size() == 0) begin
            check("idle_busy", 64'(busy0), 64'd0);
            check("idle_valid", 64'(valid0), 64'd0);
        end else begin
            check("op_busy", 64'(busy0), 64'd1);
            if (valid0) begin
                if (!seen_valid) begin
                    check("latency", 64'(cyc - start_cyc), 64'(LAT));
                    seen_valid = 1'b1;
                end
                check("result_flags", 64'({rzero0, rgt0, rcout0, res0}), 64'(exp_q[0]));
                if (ready0) begin
                    void'(exp_q.pop_front());
                    seen_valid = 1'b0;
                end
            end
        end
    end

    // ---------------- driver tasks (called at posedge + #1) ----------------
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic cin, input logic [3:0] op);
        start0 = 1'b1; a0 = a; b0 = b; cin0 = cin; op0 = op;
        @(posedge clk); #1;
        start0 = 1'b0;
        start_cyc = cyc;
        exp_q.push_back(word_model(a, b, cin, op));
    endtask

    task automatic wait_done();
        for (int i = 0; i < 40; i++) begin
            if (exp_q.size() == 0) break;
            @(posedge clk); #1;
        end
        check("done_timeout", 64'(exp_q.size()), 64'd0);
        exp_q.delete();
    endtask

    task automatic run_lit(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic cin, input logic [3:0] op,
                           input logic [EW-1:0] lit);
        issue(a, b, cin, op);
        wait_done();
        check(name, 64'({rzero0, rgt0, rcout0, res0}), 64'(lit));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int k;
        logic [W-1:0] ra, rb;
        logic rc;
        logic [3:0] rop;

        repeat (3) @(posedge clk);
        #1;
        check("reset_dut0", 64'({busy0, valid0, res0, rcout0, rgt0, rzero0, alu_a0, alu_b0,
                                  alu_cin0, alu_op0, dbg0}), 64'd0);
        check("reset_dut1", 64'({busy1, valid1, res1, rcout1, rgt1, rzero1, alu_a1, alu_b1,
                                  alu_cin1, alu_op1, dbg1}), 64'd0);
        reset_n = 1'b1;
        @(posedge clk); #1;

        // Literal expectations, packed {zero, gt, cout, result}.
        run_lit("add_basic",  16'h1234, 16'h0FCD, 1'b0, OP_ADD, {1'b0, 1'b1, 1'b0, 16'h2201});
        run_lit("add_ripple", 16'hFFFF, 16'h0001, 1'b0, OP_ADD, {1'b1, 1'b1, 1'b1, 16'h0000});
        run_lit("or_basic",   16'hA5A5, 16'h5A00, 1'b0, OP_OR,  {1'b0, 1'b1, 1'b0, 16'hFFA5});
        run_lit("gt_lsn",     16'h1234, 16'h1233, 1'b0, OP_OR,  {1'b0, 1'b1, 1'b0, 16'h1237});
        run_lit("gt_equal",   16'h1234, 16'h1234, 1'b0, OP_OR,  {1'b0, 1'b0, 1'b0, 16'h1234});
        run_lit("gt_msn_lt",  16'h1239, 16'h2231, 1'b0, OP_OR,  {1'b0, 1'b0, 1'b0, 16'h3239});
        run_lit("add_cin",    16'h7FFF, 16'h8000, 1'b1, OP_ADD, {1'b1, 1'b0, 1'b1, 16'h0000});

        // Back-pressure: hold ready low, pulse start while the result waits.
        ready0 = 1'b0;
        issue(16'h1111, 16'h2222, 1'b0, OP_ADD);
        for (int i = 0; i < 20 && !valid0; i++) begin
            @(posedge clk); #1;
        end
        check("hold_valid_seen", 64'(valid0), 64'd1);
        start0 = 1'b1; a0 = 16'hDEAD; b0 = 16'hBEEF; op0 = OP_OR;
        @(posedge clk); #1;
        @(posedge clk); #1;
        start0 = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        check("hold_busy", 64'(busy0), 64'd1);
        check("hold_valid", 64'(valid0), 64'd1);
        check("hold_result", 64'(res0), 64'h3333);
        ready0 = 1'b1;
        @(posedge clk); #1;
        check("hold_valid_drop", 64'(valid0), 64'd0);
        check("hold_busy_drop", 64'(busy0), 64'd0);
        check("hold_result_kept", 64'(res0), 64'h3333);
        check("hold_popped", 64'(exp_q.size()), 64'd0);
        exp_q.delete();

        // Random operations checked by the word model.
        for (int i = 0; i < 6; i++) begin
            ra  = W'($urandom_range(0, 65535));
            rb  = W'($urandom_range(0, 65535));
            rc  = 1'($urandom_range(0, 1));
            rop = ($urandom_range(0, 1) == 0) ? OP_ADD : OP_OR;
            issue(ra, rb, rc, rop);
            wait_done();
        end

        // SETTLE=0 instance.
        start1 = 1'b1; a1 = 16'h0001; b1 = 16'h0001; cin1 = 1'b0; op1 = OP_ADD;
        @(posedge clk); #1;
        start1 = 1'b0;
        k = 0;
        for (int i = 0; i < 12 && !valid1; i++) begin
            @(posedge clk); #1;
            k++;
        end
        check("s0_latency", 64'(k), 64'd4);
        check("s0_result", 64'({rzero1, rgt1, rcout1, res1}), 64'({1'b0, 1'b0, 1'b0, 16'h0002}));
        @(posedge clk); #1;
        check("s0_valid_drop", 64'(valid1), 64'd0);
        check("s0_busy_drop", 64'(busy1), 64'd0);

        start1 = 1'b1; a1 = 16'hFFFF; b1 = 16'h0001; cin1 = 1'b0; op1 = OP_ADD;
        @(posedge clk); #1;
        start1 = 1'b0;
        k = 0;
        for (int i = 0; i < 12 && !valid1; i++) begin
            @(posedge clk); #1;
            k++;
        end
        check("s0_ripple_latency", 64'(k), 64'd4);
        check("s0_ripple", 64'({rzero1, rgt1, rcout1, res1}), 64'({1'b1, 1'b1, 1'b1, 16'h0000}));
        @(posedge clk); #1;

        // Reset in the middle of an operation.
        issue(16'h1234, 16'h5678, 1'b0, OP_ADD);
        repeat (3) begin
            @(posedge clk); #1;
        end
        check("pre_rst_busy", 64'(busy0), 64'd1);
        reset_n = 1'b0;
        exp_q.delete();
        #1;
        check("midop_reset", 64'({busy0, valid0, res0, rcout0, rgt0, rzero0, alu_a0, alu_b0,
                                   alu_cin0, alu_op0, dbg0}), 64'd0);
        repeat (2) begin
            @(posedge clk); #1;
        end
        reset_n = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
        end
        check("no_valid_after_abort", 64'(valid0), 64'd0);
        run_lit("post_reset", 16'h0F0F, 16'h00F1, 1'b0, OP_ADD, {1'b0, 1'b1, 1'b0, 16'h1000});

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global bound on the run.
    initial begin
        #200000;
        n_checks++;
        n_fail++;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
